// File: rtl/sbox_pipe.sv
// Pipelined AES forward/inverse S-box over NBYTES lanes, one shared GF(2^8) inverter per lane,
// valid/ready flow control and a sideband tag carried with each transaction.
module sbox_pipe #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  inv_i,
    input  logic [8*NBYTES-1:0]   data_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  inv_o,
    output logic [8*NBYTES-1:0]   data_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  idle_o
);

    localparam int unsigned DW   = 8 * NBYTES;
    localparam int unsigned LAST = STAGES - 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Ops: 0 = affine-in (inverse only), 1 = inversion, 2 = affine-out (forward only).
    function automatic int unsigned op_lo(input int unsigned s);
        if (STAGES >= 3) return s;
        if (STAGES == 2) return (s == 0) ? 0 : 2;
        return 0;
    endfunction

    function automatic int unsigned op_hi(input int unsigned s);
        if (STAGES >= 3) return s;
        if (STAGES == 2) return (s == 0) ? 1 : 2;
        return 2;
    endfunction

    function automatic logic [7:0] lane_ops(input logic [7:0] b, input logic inv,
                                            input int unsigned lo, input int unsigned hi);
        logic [7:0] r;
        r = b;
        for (int unsigned op = 0; op < 3; op++) begin
            if (op >= lo && op <= hi) begin
                if (op == 0) begin
                    if (inv) r = inv_affine(r);
                end else if (op == 1) begin
                    r = gf_inv(r);
                end else if (!inv) begin
                    r = fwd_affine(r);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] stage_ops(input logic [DW-1:0] d, input logic inv,
                                                input int unsigned s);
        logic [DW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            r[8*k +: 8] = lane_ops(d[8*k +: 8], inv, op_lo(s), op_hi(s));
        end
        return r;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] inv_q;
    logic [DW-1:0]     data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] sin_v;
    logic [STAGES-1:0] sin_inv;
    logic [DW-1:0]     sin_data [STAGES];
    logic [TAG_W-1:0]  sin_tag  [STAGES];

    always_comb begin
        adv       = '0;
        adv[LAST] = ready_i || !v_q[LAST];
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            adv[s] = adv[s+1] || !v_q[s+1];
        end
        // An empty stage can always take whatever its predecessor offers.
        load = adv | ~v_q;
    end

    always_comb begin
        sin_v[0]    = valid_i;
        sin_inv[0]  = inv_i;
        sin_data[0] = stage_ops(data_i, inv_i, 0);
        sin_tag[0]  = tag_i;
        for (int unsigned s = 1; s < STAGES; s++) begin
            sin_v[s]    = v_q[s-1];
            sin_inv[s]  = inv_q[s-1];
            sin_data[s] = stage_ops(data_q[s-1], inv_q[s-1], s);
            sin_tag[s]  = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v_q   <= '0;
            inv_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    v_q[s] <= sin_v[s];
                    if (sin_v[s]) begin
                        inv_q[s]  <= sin_inv[s];
                        data_q[s] <= sin_data[s];
                        tag_q[s]  <= sin_tag[s];
                    end
                end
            end
        end
    end

    assign ready_o = load[0];
    assign valid_o = v_q[LAST];
    assign inv_o   = inv_q[LAST];
    assign data_o  = data_q[LAST];
    assign tag_o   = tag_q[LAST];
    assign idle_o  = ~|v_q;

endmodule

// File: tb/tb_sbox_pipe.sv
// Directed and scoreboarded checks for sbox_pipe against a literal FIPS-197 S-box table.
module tb_sbox_pipe;

    localparam int unsigned NB = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 8 * NB;
    localparam int unsigned WW = 1 + DW + TW;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          inv_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          inv_o;
    logic [DW-1:0] data_o;
    logic [TW-1:0] tag_o;
    logic          idle_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [WW-1:0] sb_q[$];

    logic [7:0] sbox_t [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
        8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
        8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
        8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
        8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
        8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
        8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
        8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
        8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
        8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
        8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
        8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic [7:0] isbox_t [256];

    sbox_pipe #(
        .NBYTES (NB),
        .STAGES (ST),
        .TAG_W  (TW)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .inv_i   (inv_i),
        .data_i  (data_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .inv_o   (inv_o),
        .data_o  (data_o),
        .tag_o   (tag_o),
        .idle_o  (idle_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_sub(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NB); k++) begin
            r[8*k +: 8] = inv ? isbox_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
        end
        return r;
    endfunction

    // One clock of bookkeeping: handshakes are judged at the negedge, then we move to posedge+1.
    task automatic tick(output bit acc, output bit ret, output logic [WW-1:0] exp_w,
                        output logic [WW-1:0] got_w);
        @(negedge clk);
        acc   = valid_i && ready_o;
        ret   = valid_o && ready_i;
        got_w = {inv_o, data_o, tag_o};
        exp_w = 'x;
        if (ret && sb_q.size() > 0) exp_w = sb_q.pop_front();
        if (acc) sb_q.push_back({inv_i, ref_sub(data_i, inv_i), tag_i});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        nreset  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 6;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_o); end
        if (inv_o !== 1'b0) begin n_fail++; $display("FAIL reset_inv: got %b expected 0", inv_o); end
        if (tag_o !== '0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", tag_o); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        logic [DW-1:0] vin  [3];
        logic [DW-1:0] vexp [3];
        logic          vinv [3];
        vin[0] = 32'hFF10_5300; vexp[0] = 32'h16CA_ED63; vinv[0] = 1'b0;
        vin[1] = 32'h16CA_ED63; vexp[1] = 32'hFF10_5300; vinv[1] = 1'b1;
        vin[2] = 32'h0000_0000; vexp[2] = 32'h5252_5252; vinv[2] = 1'b1;
        ready_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            valid_i = 1'b1;
            inv_i   = vinv[t];
            data_i  = vin[t];
            tag_i   = TW'(t + 5);
            n_checks++;
            if (ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected 1", t, ready_o); end
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            data_i  = 32'hDEAD_BEEF;
            for (int i = 0; i < int'(ST) - 1; i++) begin
                n_checks++;
                if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early[%0d]: got %b expected 0", t, valid_o); end
                @(posedge clk);
                #1;
            end
            n_checks += 2;
            if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", t, valid_o); end
            if ({inv_o, data_o, tag_o} !== {vinv[t], vexp[t], TW'(t + 5)}) begin
                n_fail++;
                $display("FAIL single_data[%0d]: got %b/%h/%h expected %b/%h/%h", t, inv_o, data_o,
                         tag_o, vinv[t], vexp[t], TW'(t + 5));
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (idle_o !== 1'b1) begin n_fail++; $display("FAIL single_idle[%0d]: got %b expected 1", t, idle_o); end
        end
    endtask

    task automatic test_back_to_back;
        bit acc, ret;
        logic [WW-1:0] e, g;
        int sent = 0, nret = 0, noready = 0, first = -1, last = -1;
        ready_i = 1'b1;
        for (int c = 0; c < 700 && (sent < 512 || sb_q.size() > 0); c++) begin
            if (sent < 512) begin
                valid_i = 1'b1;
                inv_i   = sent[0] ^ sent[8];
                tag_i   = TW'(sent);
                for (int k = 0; k < int'(NB); k++) data_i[8*k +: 8] = 8'(sent + 37 * k);
            end else begin
                valid_i = 1'b0;
            end
            tick(acc, ret, e, g);
            if (valid_i && !acc) noready++;
            if (acc) sent++;
            if (ret) begin
                nret++;
                if (first < 0) first = cyc;
                last = cyc;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", nret, g, e); end
            end
        end
        valid_i = 1'b0;
        n_checks += 3;
        if (noready != 0) begin n_fail++; $display("FAIL b2b_ready_drops: got %0d expected 0", noready); end
        if (nret != 512) begin n_fail++; $display("FAIL b2b_count: got %0d expected 512", nret); end
        if (last - first + 1 != 512) begin
            n_fail++;
            $display("FAIL b2b_span: got %0d cycles expected 512", last - first + 1);
        end
    endtask

    task automatic test_backpressure;
        bit acc, ret;
        logic [WW-1:0] e, g, hold;
        int sent = 0, nret = 0;
        int total = int'(ST) + 2;
        ready_i = 1'b0;
        for (int c = 0; c < total; c++) begin
            valid_i = 1'b1;
            inv_i   = sent[0];
            tag_i   = TW'(sent + 3);
            data_i  = 32'h1357_9BDF ^ (32'h0102_0408 * sent);
            tick(acc, ret, e, g);
            if (acc) sent++;
        end
        n_checks += 4;
        if (sent != int'(ST)) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", sent, ST); end
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", ready_o); end
        if (idle_o !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", idle_o); end
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", valid_o); end
        hold = {inv_o, data_o, tag_o};
        repeat (3) tick(acc, ret, e, g);
        n_checks += 2;
        if ({inv_o, data_o, tag_o} !== hold) begin
            n_fail++;
            $display("FAIL bp_stable: got %h expected %h", {inv_o, data_o, tag_o}, hold);
        end
        if (acc) begin n_fail++; $display("FAIL bp_accept_when_full: got 1 expected 0"); end
        ready_i = 1'b1;
        for (int c = 0; c < 50 && (sent < total || sb_q.size() > 0); c++) begin
            if (sent < total) begin
                valid_i = 1'b1;
                inv_i   = sent[0];
                tag_i   = TW'(sent + 3);
                data_i  = 32'h1357_9BDF ^ (32'h0102_0408 * sent);
            end else begin
                valid_i = 1'b0;
            end
            tick(acc, ret, e, g);
            if (acc) sent++;
            if (ret) begin
                nret++;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", nret, g, e); end
            end
        end
        valid_i = 1'b0;
        n_checks++;
        if (nret != total) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", nret, total); end
    endtask

    task automatic test_random_stall;
        bit acc, ret;
        bit acc_prev = 1'b1;
        logic [WW-1:0] e, g, pre_w;
        logic pre_v, pre_rdy;
        int n_acc = 0, n_ret = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!valid_i || acc_prev) begin
                valid_i = ($urandom_range(0, 3) != 0);
                data_i  = $urandom;
                inv_i   = 1'($urandom_range(0, 1));
                tag_i   = TW'($urandom);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            pre_v   = valid_o;
            pre_rdy = ready_i;
            pre_w   = {inv_o, data_o, tag_o};
            tick(acc, ret, e, g);
            acc_prev = acc;
            if (acc) n_acc++;
            if (ret) begin
                n_ret++;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", n_ret, g, e); end
            end
            if (pre_v && !pre_rdy) begin
                n_checks++;
                if (!valid_o || {inv_o, data_o, tag_o} !== pre_w) begin
                    n_fail++;
                    $display("FAIL rand_stable: got %b/%h expected 1/%h", valid_o,
                             {inv_o, data_o, tag_o}, pre_w);
                end
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
            tick(acc, ret, e, g);
            if (ret) begin
                n_ret++;
                n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL rand_drain[%0d]: got %h expected %h", n_ret, g, e); end
            end
        end
        n_checks++;
        if (n_ret != n_acc || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d retired expected %0d", n_ret, n_acc);
        end
    endtask

    task automatic test_reset_mid;
        bit acc, ret;
        logic [WW-1:0] e, g;
        int sent = 0, nret = 0;
        ready_i = 1'b0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            valid_i = 1'b1;
            inv_i   = 1'b0;
            data_i  = 32'hA5A5_0F0F + sent;
            tag_i   = TW'(sent + 1);
            tick(acc, ret, e, g);
            if (acc) sent++;
        end
        valid_i = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        n_checks += 5;
        if (sent != 2) begin n_fail++; $display("FAIL rst_setup: got %0d expected 2", sent); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", idle_o); end
        if (data_o !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", data_o); end
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready_o); end
        sb_q.delete();
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        inv_i   = 1'b1;
        data_i  = 32'h16CA_ED63;
        tag_i   = 4'h9;
        tick(acc, ret, e, g);
        valid_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(acc, ret, e, g);
            if (ret) begin
                nret++;
                n_checks++;
                if (g !== {1'b1, 32'hFF10_5300, 4'h9}) begin
                    n_fail++;
                    $display("FAIL rst_first_out[%0d]: got %h expected %h", nret, g,
                             {1'b1, 32'hFF10_5300, 4'h9});
                end
            end
        end
        n_checks++;
        if (nret != 1) begin n_fail++; $display("FAIL rst_out_count: got %0d expected 1", nret); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
